// File: rtl/spi_pkg.sv
// spi_pkg: shared frame geometry and FSM state encoding for the SPI target
package spi_pkg;
  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 8;
  localparam int HDR_W   = 16;
  localparam int RNW_BIT = 15;
  typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer with rise/fall detection on the synchronized value
module spi_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  // shift the raw input through the chain; keep last synchronized value for edge detect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= {STAGES{IDLE_VAL}};
      r_prev <= IDLE_VAL;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(i_d);
      r_prev <= r_sync[STAGES-1];
    end
  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 register-access target (16-bit header + data byte); SPI_TARGET_STREAM_EN enables auto-increment streaming
module spi_target
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              CSB,
  inout  wire               SDIO,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              wr_o,
  output logic              rd_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o
);
  state_t              r_state, w_next;
  logic                w_sclk_rise, w_sclk_fall, w_csb_q, w_csb_rise, w_csb_fall, w_sdi;
  logic                w_unused_sclk_q, w_unused_sdi_rise, w_unused_sdi_fall;
  logic                w_hdr_done, w_byte_done;
  logic [HDR_W-2:0]    r_hdr;
  logic [DATA_W-1:0]   r_shift, r_wdata;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_cnt;
  logic [7:0]          r_arm_cnt;
  logic                r_armed, r_rnw, r_wr, r_rd, r_oe, r_sdo;

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk (
    .clk(CLK), .rst_n(RST), .i_d(SCLK), .o_q(w_unused_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_csb (
    .clk(CLK), .rst_n(RST), .i_d(CSB), .o_q(w_csb_q), .o_rise(w_csb_rise), .o_fall(w_csb_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sdio (
    .clk(CLK), .rst_n(RST), .i_d(SDIO), .o_q(w_sdi), .o_rise(w_unused_sdi_rise), .o_fall(w_unused_sdi_fall));

  assign w_hdr_done  = (r_state == HEADER) && w_sclk_rise && (r_cnt == 4'(HDR_W - 1));
  assign w_byte_done = (r_state == DATA) && w_sclk_rise && (r_cnt == 4'(DATA_W - 1));

  // state register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;

  // next state: CSB rise always returns to IDLE; a frame only starts from an armed IDLE
  always_comb begin
    w_next = r_state;
    if (w_csb_rise) w_next = IDLE;
    else
      case (r_state)
        IDLE:    w_next = (w_csb_fall && r_armed) ? HEADER : IDLE;
        HEADER:  w_next = w_hdr_done ? DATA : HEADER;
`ifdef SPI_TARGET_STREAM_EN
        DATA:    w_next = DATA;
`else
        DATA:    w_next = w_byte_done ? DONE : DATA;
`endif
        default: w_next = DONE;
      endcase
  end

  // datapath: header/data shifting, strobes, read shift-out and SDIO enable.
  // Arming needs CSB seen high longer than the synchronizer depth, so a CSB held
  // low across reset release cannot fake a start-of-frame.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_hdr     <= '0;
      r_shift   <= '0;
      r_wdata   <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
      r_rnw     <= 1'b0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_oe      <= 1'b0;
      r_sdo     <= 1'b0;
    end else begin
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_arm_cnt <= (w_csb_q && !r_armed) ? r_arm_cnt + 1'b1 : '0;
      r_armed   <= r_armed | (r_arm_cnt == 8'(SYNC_STAGES + 1));
      if (w_csb_rise || r_state == IDLE) begin
        r_oe  <= 1'b0;
        r_cnt <= '0;
      end else begin
        if (r_state == HEADER && w_sclk_rise) begin
          r_hdr <= {r_hdr[HDR_W-3:0], w_sdi};
          r_cnt <= w_hdr_done ? '0 : r_cnt + 1'b1;
          if (w_hdr_done) begin
            r_addr <= {r_hdr[ADDR_W-2:0], w_sdi};
            r_rnw  <= r_hdr[RNW_BIT-1];
            r_rd   <= r_hdr[RNW_BIT-1];
          end
        end
        if (r_state == DATA && w_sclk_rise) begin
          r_cnt <= w_byte_done ? '0 : r_cnt + 1'b1;
          if (!r_rnw) r_shift <= {r_shift[DATA_W-2:0], w_sdi};
          if (w_byte_done && !r_rnw) begin
            r_wdata <= {r_shift[DATA_W-2:0], w_sdi};
            r_wr    <= 1'b1;
          end
`ifdef SPI_TARGET_STREAM_EN
          if (w_byte_done && r_rnw) begin
            r_rd   <= 1'b1;
            r_addr <= r_addr + 1'b1;
          end
`endif
        end
        if (r_state == DATA && w_sclk_fall && r_rnw) begin
          r_oe    <= 1'b1;
          r_sdo   <= r_shift[DATA_W-1];
          r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        end
        if (r_state == DONE && w_sclk_fall) r_oe <= 1'b0;
`ifdef SPI_TARGET_STREAM_EN
        if (r_wr) r_addr <= r_addr + 1'b1;
`endif
        if (r_rd) r_shift <= rdata_i;
      end
    end

  assign SDIO    = r_oe ? r_sdo : 1'bz;
  assign addr_o  = r_addr;
  assign wdata_o = r_wdata;
  assign wr_o    = r_wr;
  assign rd_o    = r_rd;
  assign busy_o  = (r_state != IDLE);
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: table-driven directed bench for spi_target plus reset-abort and streaming sequences
module tb_spi_target;
`ifdef SPI_TARGET_STREAM_EN
  localparam int STREAM = 1;
`else
  localparam int STREAM = 0;
`endif

  logic        CLK = 1'b0, RST = 1'b0, SCLK = 1'b0, CSB = 1'b1;
  logic [7:0]  rdata_i = 8'h00;
  logic        tb_oe = 1'b0, tb_sdo = 1'b0;
  wire         SDIO;
  logic [12:0] addr_o;
  logic [7:0]  wdata_o;
  logic        wr_o, rd_o, busy_o;

  assign SDIO = tb_oe ? tb_sdo : 1'bz;
  always #5 CLK = ~CLK;

  spi_target dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .CSB(CSB), .SDIO(SDIO),
    .addr_o(addr_o), .wdata_o(wdata_o), .wr_o(wr_o), .rd_o(rd_o),
    .rdata_i(rdata_i), .busy_o(busy_o));

  int checks = 0, failures = 0, both = 0;
  logic        dut_drove = 1'b0;
  logic [12:0] wr_addr[$], rd_addr[$];
  logic [7:0]  wr_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (wr_o) begin
      wr_addr.push_back(addr_o);
      wr_data.push_back(wdata_o);
    end
    if (rd_o) rd_addr.push_back(addr_o);
    if (wr_o && rd_o) both++;
    if (!tb_oe && SDIO !== 1'bz) dut_drove = 1'b1;
    if (tb_oe && SDIO !== tb_sdo) dut_drove = 1'b1;
  end

  task automatic frame(input logic [15:0] hdr, input logic [15:0] dat, input int nbits,
                       input int rst_bit, output logic [7:0] rbits);
    rbits = 8'h00;
    CSB = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      tb_oe  = (i < 16) || !hdr[15];
      tb_sdo = (i < 16) ? hdr[15-i] : dat[31-i];
      wait_clk(8);
      if (i >= 16) rbits = {rbits[6:0], SDIO};
      SCLK = 1'b1;
      wait_clk(4);
      if (i == rst_bit) begin
        RST = 1'b0;
        wait_clk(2);
        chk("rst_mid_addr", 32'(addr_o), 32'h0);
        chk("rst_mid_wdata", 32'(wdata_o), 32'h0);
        chk("rst_mid_wr", 32'(wr_o), 32'h0);
        chk("rst_mid_rd", 32'(rd_o), 32'h0);
        chk("rst_mid_busy", 32'(busy_o), 32'h0);
        RST = 1'b1;
      end
      wait_clk(4);
      SCLK = 1'b0;
    end
    wait_clk(8);
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
    dut_drove = 1'b0;
  endtask

  typedef struct {
    logic [15:0] hdr;
    logic [7:0]  wdat;
    logic [7:0]  rdata;
    int          nbits;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  vec_t        vt[8];
  logic [7:0]  rb;
  logic [12:0] prev_addr, exp_addr;
  logic [7:0]  prev_wdata;
  logic        full, rnw;

  initial begin
    vt[0] = '{16'h0123, 8'hA5, 8'h00, 24, 1, 0};
    vt[1] = '{16'h8456, 8'h00, 8'h3C, 24, 0, 1};
    vt[2] = '{16'h0ABC, 8'hFF, 8'h00, 10, 0, 0};
    vt[3] = '{16'h0001, 8'h11, 8'h00, 24, 1, 0};
    vt[4] = '{16'hFFFF, 8'h00, 8'h81, 24, 0, 1};
    vt[5] = '{16'h6AAA, 8'h5A, 8'h00, 24, 1, 0};
    vt[6] = '{16'h8010, 8'h00, 8'hFF, 20, 0, 1};
    vt[7] = '{16'h0055, 8'hC3, 8'h00, 20, 0, 0};

    wait_clk(3);
    chk("reset_addr", 32'(addr_o), 32'h0);
    chk("reset_wdata", 32'(wdata_o), 32'h0);
    chk("reset_wr", 32'(wr_o), 32'h0);
    chk("reset_rd", 32'(rd_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    chk("reset_sdio_z", 32'(SDIO === 1'bz), 32'h1);
    RST = 1'b1;
    wait_clk(10);
    prev_addr  = 13'h0;
    prev_wdata = 8'h00;

    for (int k = 0; k < 8; k++) begin
      clear_mon();
      rdata_i = vt[k].rdata;
      full    = (vt[k].nbits == 24);
      rnw     = vt[k].hdr[15];
      frame(vt[k].hdr, {vt[k].wdat, 8'h00}, vt[k].nbits, -1, rb);
`ifndef SPI_TARGET_STREAM_EN
      if (full && rnw) chk($sformatf("v%0d_release_after_bit0", k), 32'(SDIO === 1'bz), 32'h1);
`endif
      chk($sformatf("v%0d_busy_in_frame", k), 32'(busy_o), 32'h1);
      CSB   = 1'b1;
      tb_oe = 1'b0;
      wait_clk(8);
      chk($sformatf("v%0d_sdio_z_after_csb", k), 32'(SDIO === 1'bz), 32'h1);
      chk($sformatf("v%0d_busy_idle", k), 32'(busy_o), 32'h0);
      chk($sformatf("v%0d_wr_count", k), 32'(wr_addr.size()), 32'(vt[k].exp_wr));
      chk($sformatf("v%0d_rd_count", k), 32'(rd_addr.size()),
          32'(vt[k].exp_rd + ((STREAM == 1 && full && rnw) ? 1 : 0)));
      if (wr_addr.size() > 0) begin
        chk($sformatf("v%0d_wr_addr", k), 32'(wr_addr[0]), 32'(vt[k].hdr[12:0]));
        chk($sformatf("v%0d_wr_data", k), 32'(wr_data[0]), 32'(vt[k].wdat));
      end
      if (rd_addr.size() > 0) chk($sformatf("v%0d_rd_addr", k), 32'(rd_addr[0]), 32'(vt[k].hdr[12:0]));
      exp_addr = (vt[k].nbits >= 16) ? vt[k].hdr[12:0] + ((STREAM == 1 && full) ? 13'h1 : 13'h0) : prev_addr;
      if (!rnw && full) prev_wdata = vt[k].wdat;
      prev_addr = exp_addr;
      chk($sformatf("v%0d_addr_o", k), 32'(addr_o), 32'(exp_addr));
      chk($sformatf("v%0d_wdata_o", k), 32'(wdata_o), 32'(prev_wdata));
      if (full && rnw) chk($sformatf("v%0d_read_bits", k), 32'(rb), 32'(vt[k].rdata));
      chk($sformatf("v%0d_sdio_driven", k), 32'(dut_drove), 32'(rnw && vt[k].nbits > 16));
      wait_clk(4);
    end

    // reset asserted during the fourth data bit of a write, CSB held low across release
    clear_mon();
    frame(16'h0077, 16'hC300, 24, 19, rb);
    chk("rstseq_busy_no_refall", 32'(busy_o), 32'h0);
    CSB   = 1'b1;
    tb_oe = 1'b0;
    wait_clk(8);
    chk("rstseq_no_wr", 32'(wr_addr.size()), 32'h0);
    chk("rstseq_addr", 32'(addr_o), 32'h0);
    chk("rstseq_wdata", 32'(wdata_o), 32'h0);
    clear_mon();
    frame(16'h0001, 16'h1100, 24, -1, rb);
    CSB   = 1'b1;
    tb_oe = 1'b0;
    wait_clk(8);
    chk("rstseq_next_wr_count", 32'(wr_addr.size()), 32'h1);
    if (wr_addr.size() > 0) begin
      chk("rstseq_next_wr_addr", 32'(wr_addr[0]), 32'h0001);
      chk("rstseq_next_wr_data", 32'(wr_data[0]), 32'h11);
    end

    // two-byte write at the top of the address space
    clear_mon();
    frame(16'h1FFF, 16'h0102, 32, -1, rb);
    CSB   = 1'b1;
    tb_oe = 1'b0;
    wait_clk(8);
    chk("stream_wr_count", 32'(wr_addr.size()), 32'(STREAM == 1 ? 2 : 1));
    if (wr_addr.size() > 0) begin
      chk("stream_wr0_addr", 32'(wr_addr[0]), 32'h1FFF);
      chk("stream_wr0_data", 32'(wr_data[0]), 32'h01);
    end
`ifdef SPI_TARGET_STREAM_EN
    if (wr_addr.size() > 1) begin
      chk("stream_wr1_addr", 32'(wr_addr[1]), 32'h0000);
      chk("stream_wr1_data", 32'(wr_data[1]), 32'h02);
    end
`endif
    chk("stream_final_addr", 32'(addr_o), 32'(STREAM == 1 ? 13'h0001 : 13'h1FFF));
    chk("never_wr_and_rd", 32'(both), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
